// File: rtl/trg_frame_builder.sv
// Trigger frame builder: packs each trigger window into a header/data/footer
// frame and streams it out of a first-word-fall-through FIFO on AXI4-Stream.
module trg_frame_builder #(
    parameter logic [7:0] CHANNEL_ID         = 8'd0,
    parameter int         DATA_DELAY         = 4,
    parameter int         FIFO_DEPTH         = 512,
    parameter int         TIME_STAMP_WIDTH   = 16,
    parameter int         S_AXIS_TDATA_WIDTH = 128
) (
    input  logic                          AXIS_ACLK,
    input  logic                          AXIS_ARESET,
    input  logic [1:0]                    EXEC_STATE,
    input  logic                          TRIG_FLAG,
    input  logic [TIME_STAMP_WIDTH-1:0]   TIME_STAMP,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
    output logic [S_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                          M_AXIS_TVALID,
    input  logic                          M_AXIS_TREADY,
    output logic                          M_AXIS_TLAST,
    output logic [15:0]                   DROP_COUNT
);
    localparam int W  = S_AXIS_TDATA_WIDTH;
    localparam int DL = DATA_DELAY + 2;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BODY,
        S_SKIP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic          r_f1;
    logic          r_f2;
    logic          r_f3;
    logic          w_hdr_ev;
    logic          w_dat_ev;
    logic          w_ftr_ev;
    logic          w_trg;

    logic [W-1:0]  r_dly [DL];

    logic [W:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW-1:0] w_occ;
    logic [AW:0]   w_free;
    logic          w_room_hdr;
    logic          w_room_dat;
    logic          w_valid;
    logic          w_pop;
    logic [W:0]    w_head;

    logic          w_push;
    logic          w_wlast;
    logic [W-1:0]  w_wdata;
    logic [W-1:0]  w_hdr;
    logic [W-1:0]  w_ftr;
    logic [15:0]   w_ts;

    logic [15:0]   r_cnt;
    logic [15:0]   w_cnt_nxt;
    logic          r_ovf;
    logic          w_ovf_nxt;
    logic [15:0]   r_drop;
    logic          w_drop_inc;

    // Flag pipeline and event strobes
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            r_f1 <= 1'b0;
            r_f2 <= 1'b0;
            r_f3 <= 1'b0;
        end else begin
            r_f1 <= TRIG_FLAG;
            r_f2 <= r_f1;
            r_f3 <= r_f2;
        end
    end

    assign w_hdr_ev = r_f1 & ~r_f2;
    assign w_dat_ev = r_f2;
    assign w_ftr_ev = ~r_f2 & r_f3;
    assign w_trg    = (EXEC_STATE == 2'b11);

    // Sample delay line, aligns pre-trigger words with the f2 window
    always_ff @(posedge AXIS_ACLK) begin
        r_dly[0] <= S_AXIS_TDATA;
        for (int i = 1; i < DL; i++) begin
            r_dly[i] <= r_dly[i-1];
        end
    end

    assign w_ts = 16'(TIME_STAMP);

    always_comb begin
        w_hdr              = '0;
        w_hdr[W-1 -: 8]    = 8'hAA;
        w_hdr[W-9 -: 8]    = CHANNEL_ID;
        w_hdr[W-17 -: 16]  = w_ts;
        w_ftr              = '0;
        w_ftr[W-1 -: 8]    = 8'h55;
        w_ftr[W-9 -: 8]    = CHANNEL_ID;
        w_ftr[W-17 -: 16]  = r_cnt;
        w_ftr[W-33]        = r_ovf;
    end

    // Pointer FIFO without wrap bit: usable capacity is FIFO_DEPTH-1
    assign w_occ      = r_wptr - r_rptr;
    assign w_valid    = (w_occ != '0);
    assign w_free     = (AW+1)'(FIFO_DEPTH - 1) - {1'b0, w_occ};
    assign w_room_hdr = (w_free >= (AW+1)'(3));
    assign w_room_dat = (w_free >= (AW+1)'(2));
    assign w_pop      = w_valid & M_AXIS_TREADY;
    assign w_head     = r_mem[r_rptr];

    always_ff @(posedge AXIS_ACLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= {w_wlast, w_wdata};
        end
    end

    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
        end
    end

    assign M_AXIS_TVALID = w_valid;
    assign M_AXIS_TDATA  = w_valid ? w_head[W-1:0] : '0;
    assign M_AXIS_TLAST  = w_valid & w_head[W];
    assign DROP_COUNT    = r_drop;

    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_drop  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
            if (w_drop_inc && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        w_drop_inc  = 1'b0;
        w_push      = 1'b0;
        w_wlast     = 1'b0;
        w_wdata     = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_hdr_ev) begin
                    if (w_trg && !w_ftr_ev && w_room_hdr) begin
                        w_push      = 1'b1;
                        w_wdata     = w_hdr;
                        w_cnt_nxt   = '0;
                        w_ovf_nxt   = 1'b0;
                        w_state_nxt = S_BODY;
                    end else begin
                        w_drop_inc  = w_trg;
                        w_state_nxt = S_SKIP;
                    end
                end
            end
            S_BODY: begin
                if (w_ftr_ev) begin
                    // Footer slot is always reserved, so no room check here
                    w_push      = 1'b1;
                    w_wlast     = 1'b1;
                    w_wdata     = w_ftr;
                    w_cnt_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                    w_drop_inc  = w_hdr_ev & w_trg;
                    w_state_nxt = w_hdr_ev ? S_SKIP : S_IDLE;
                end else if (w_dat_ev) begin
                    if (w_room_dat) begin
                        w_push  = 1'b1;
                        w_wdata = r_dly[DL-1];
                        if (r_cnt != 16'hFFFF) begin
                            w_cnt_nxt = r_cnt + 16'd1;
                        end
                    end else begin
                        w_ovf_nxt = 1'b1;
                    end
                end
            end
            S_SKIP: begin
                if (w_ftr_ev) begin
                    w_drop_inc  = w_hdr_ev & w_trg;
                    w_state_nxt = w_hdr_ev ? S_SKIP : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_trg_frame_builder.sv
// Directed bench for trg_frame_builder: framing, overflow, drop, reset and
// AXI-Stream stall behaviour against hand-computed frames.
module tb_trg_frame_builder;
    localparam int W = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    exec = 2'b00;
    logic          flag = 1'b0;
    logic [15:0]   ts = 16'h0;
    logic [W-1:0]  sdata = '0;
    logic          tready = 1'b1;
    logic          tready8 = 1'b1;

    logic [W-1:0]  tdata;
    logic          tvalid;
    logic          tlast;
    logic [15:0]   drop;
    logic [W-1:0]  tdata8;
    logic          tvalid8;
    logic          tlast8;
    logic [15:0]   drop8;

    int checks = 0;
    int errors = 0;

    logic [W:0] q[$];
    logic [W:0] q8[$];
    logic [W:0] exp_q[$];

    always #5 clk = ~clk;

    trg_frame_builder #(.FIFO_DEPTH(512)) dut (
        .AXIS_ACLK     (clk),
        .AXIS_ARESET   (rst),
        .EXEC_STATE    (exec),
        .TRIG_FLAG     (flag),
        .TIME_STAMP    (ts),
        .S_AXIS_TDATA  (sdata),
        .M_AXIS_TDATA  (tdata),
        .M_AXIS_TVALID (tvalid),
        .M_AXIS_TREADY (tready),
        .M_AXIS_TLAST  (tlast),
        .DROP_COUNT    (drop)
    );

    trg_frame_builder #(.FIFO_DEPTH(8)) dut8 (
        .AXIS_ACLK     (clk),
        .AXIS_ARESET   (rst),
        .EXEC_STATE    (exec),
        .TRIG_FLAG     (flag),
        .TIME_STAMP    (ts),
        .S_AXIS_TDATA  (sdata),
        .M_AXIS_TDATA  (tdata8),
        .M_AXIS_TVALID (tvalid8),
        .M_AXIS_TREADY (tready8),
        .M_AXIS_TLAST  (tlast8),
        .DROP_COUNT    (drop8)
    );

    // Transfers are recorded mid-cycle; the pop happens at the next rising edge
    always @(negedge clk) begin
        if (tvalid && tready) q.push_back({tlast, tdata});
        if (tvalid8 && tready8) q8.push_back({tlast8, tdata8});
    end

    task automatic tick();
        @(posedge clk);
        #1;
        sdata = sdata + 1;
    endtask

    task automatic drive(input int n, input int a0, input int a1,
                         input int b0, input int b1, input int xoff);
        for (int i = 0; i < n; i++) begin
            flag = (sdata >= W'(a0) && sdata <= W'(a1)) ||
                   (sdata >= W'(b0) && sdata <= W'(b1));
            if (xoff != 0 && sdata >= W'(xoff)) exec = 2'b00;
            tick();
        end
        flag = 1'b0;
    endtask

    task automatic add_frame(input logic [15:0] t, input int first,
                             input int n, input int cnt, input logic ovf);
        logic [W:0] w;
        w = '0;
        w[127:120] = 8'hAA;
        w[111:96]  = t;
        exp_q.push_back(w);
        for (int k = 0; k < n; k++) begin
            w = '0;
            w[31:0] = 32'(first + k);
            exp_q.push_back(w);
        end
        w = '0;
        w[128]     = 1'b1;
        w[127:120] = 8'h55;
        w[111:96]  = 16'(cnt);
        w[95]      = ovf;
        exp_q.push_back(w);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tvalid !== 1'b0) begin
            errors++; $display("FAIL reset_tvalid got %b exp 0", tvalid);
        end
        checks++;
        if (tlast !== 1'b0) begin
            errors++; $display("FAIL reset_tlast got %b exp 0", tlast);
        end
        checks++;
        if (tdata !== '0) begin
            errors++; $display("FAIL reset_tdata got %h exp 0", tdata);
        end
        checks++;
        if (drop !== 16'd0) begin
            errors++; $display("FAIL reset_drop got %0d exp 0", drop);
        end
        checks++;
        if (tvalid8 !== 1'b0) begin
            errors++; $display("FAIL reset_tvalid8 got %b exp 0", tvalid8);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        exec = 2'b11; ts = 16'h1234; tready = 1'b1;
        q.delete(); exp_q.delete();
        sdata = 90;
        drive(40, 100, 109, 1, 0, 0);
        add_frame(16'h1234, 96, 10, 10, 1'b0);
        checks++;
        if (q.size() !== exp_q.size()) begin
            errors++; $display("FAIL basic_len got %0d exp %0d", q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < q.size()) begin
            checks++;
            if (q[i] !== exp_q[i]) begin
                errors++; $display("FAIL basic_word%0d got %h exp %h", i, q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_overflow();
        exec = 2'b11; ts = 16'h1234; tready8 = 1'b0;
        q8.delete(); exp_q.delete();
        sdata = 90;
        drive(40, 100, 109, 1, 0, 0);
        checks++;
        if (q8.size() !== 0 || tvalid8 !== 1'b1) begin
            errors++; $display("FAIL ovf_stalled got %0d words valid %b exp 0 words valid 1", q8.size(), tvalid8);
        end
        tready8 = 1'b1;
        drive(20, 1, 0, 1, 0, 0);
        add_frame(16'h1234, 96, 5, 5, 1'b1);
        checks++;
        if (q8.size() !== exp_q.size()) begin
            errors++; $display("FAIL ovf_len got %0d exp %0d", q8.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < q8.size()) begin
            checks++;
            if (q8[i] !== exp_q[i]) begin
                errors++; $display("FAIL ovf_word%0d got %h exp %h", i, q8[i], exp_q[i]);
            end
        end
        checks++;
        if (drop8 !== 16'd0) begin
            errors++; $display("FAIL ovf_drop got %0d exp 0", drop8);
        end
    endtask

    task automatic test_exec_idle();
        exec = 2'b00; q.delete();
        sdata = 90;
        drive(40, 100, 109, 1, 0, 0);
        checks++;
        if (q.size() !== 0 || tvalid !== 1'b0) begin
            errors++; $display("FAIL idle_words got %0d valid %b exp 0 valid 0", q.size(), tvalid);
        end
        checks++;
        if (drop !== 16'd0) begin
            errors++; $display("FAIL idle_drop got %0d exp 0", drop);
        end
    endtask

    task automatic test_exec_leave();
        exec = 2'b11; ts = 16'hBEEF;
        q.delete(); exp_q.delete();
        sdata = 90;
        drive(40, 100, 109, 1, 0, 104);
        add_frame(16'hBEEF, 96, 10, 10, 1'b0);
        checks++;
        if (q.size() !== exp_q.size()) begin
            errors++; $display("FAIL leave_len got %0d exp %0d", q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < q.size()) begin
            checks++;
            if (q[i] !== exp_q[i]) begin
                errors++; $display("FAIL leave_word%0d got %h exp %h", i, q[i], exp_q[i]);
            end
        end
        exec = 2'b11;
    endtask

    task automatic test_reset_mid();
        exec = 2'b11; ts = 16'h1234; tready = 1'b0;
        q.delete(); exp_q.delete();
        sdata = 90;
        for (int i = 0; i < 25; i++) begin
            flag = (sdata >= 100 && sdata <= 109);
            if (sdata == 108) begin
                checks++;
                if (tvalid !== 1'b1) begin
                    errors++; $display("FAIL rmid_pre_valid got %b exp 1", tvalid);
                end
                #3 rst = 1'b1;
                #1;
                checks++;
                if (tvalid !== 1'b0 || tdata !== '0) begin
                    errors++; $display("FAIL rmid_async got valid %b data %h exp 0", tvalid, tdata);
                end
            end
            if (sdata == 110) #3 rst = 1'b0;
            tick();
        end
        flag = 1'b0;
        tready = 1'b1;
        drive(10, 1, 0, 1, 0, 0);
        checks++;
        if (q.size() !== 0 || tvalid !== 1'b0) begin
            errors++; $display("FAIL rmid_empty got %0d words valid %b exp 0", q.size(), tvalid);
        end
        checks++;
        if (drop !== 16'd0) begin
            errors++; $display("FAIL rmid_drop got %0d exp 0", drop);
        end
        ts = 16'h0777;
        sdata = 90;
        drive(40, 100, 109, 1, 0, 0);
        add_frame(16'h0777, 96, 10, 10, 1'b0);
        checks++;
        if (q.size() !== exp_q.size()) begin
            errors++; $display("FAIL rmid_len got %0d exp %0d", q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < q.size()) begin
            checks++;
            if (q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rmid_word%0d got %h exp %h", i, q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_collision();
        int nlast;
        exec = 2'b11; ts = 16'h1234;
        q.delete(); exp_q.delete();
        sdata = 90;
        drive(50, 100, 105, 107, 112, 0);
        add_frame(16'h1234, 96, 6, 6, 1'b0);
        checks++;
        if (q.size() !== exp_q.size()) begin
            errors++; $display("FAIL coll_len got %0d exp %0d", q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < q.size()) begin
            checks++;
            if (q[i] !== exp_q[i]) begin
                errors++; $display("FAIL coll_word%0d got %h exp %h", i, q[i], exp_q[i]);
            end
        end
        nlast = 0;
        foreach (q[i]) if (q[i][W]) nlast++;
        checks++;
        if (nlast !== 1) begin
            errors++; $display("FAIL coll_tlast got %0d exp 1", nlast);
        end
        checks++;
        if (drop !== 16'd1) begin
            errors++; $display("FAIL coll_drop got %0d exp 1", drop);
        end
    endtask

    task automatic test_back_to_back();
        logic         pv;
        logic         pr;
        logic         pl;
        logic [W-1:0] pd;
        int           nlast;
        exec = 2'b11; ts = 16'h1234;
        q.delete(); exp_q.delete();
        pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = '0;
        sdata = 90;
        for (int i = 0; i < 80; i++) begin
            flag = (sdata >= 100 && sdata <= 103) ||
                   (sdata >= 110 && sdata <= 113) ||
                   (sdata >= 120 && sdata <= 123);
            tready = (i % 2 == 1);
            @(negedge clk);
            if (pv && !pr) begin
                checks++;
                if (tvalid !== 1'b1 || tdata !== pd || tlast !== pl) begin
                    errors++;
                    $display("FAIL b2b_stall got %b/%h/%b exp 1/%h/%b", tvalid, tdata, tlast, pd, pl);
                end
            end
            pv = tvalid; pr = tready; pd = tdata; pl = tlast;
            tick();
        end
        flag = 1'b0;
        tready = 1'b1;
        drive(20, 1, 0, 1, 0, 0);
        add_frame(16'h1234, 96, 4, 4, 1'b0);
        add_frame(16'h1234, 106, 4, 4, 1'b0);
        add_frame(16'h1234, 116, 4, 4, 1'b0);
        checks++;
        if (q.size() !== exp_q.size()) begin
            errors++; $display("FAIL b2b_len got %0d exp %0d", q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < q.size()) begin
            checks++;
            if (q[i] !== exp_q[i]) begin
                errors++; $display("FAIL b2b_word%0d got %h exp %h", i, q[i], exp_q[i]);
            end
        end
        nlast = 0;
        foreach (q[i]) if (q[i][W]) nlast++;
        checks++;
        if (nlast !== 3) begin
            errors++; $display("FAIL b2b_tlast got %0d exp 3", nlast);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_exec_idle();
        test_exec_leave();
        test_reset_mid();
        test_collision();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trg_frame_builder.md
Name: trg_frame_builder

Overview:
- Downstream of the minimum-trigger stage, on the same AXIS_ACLK domain.
- Consumes the trigger flag, the latched time stamp and the same RF Data Converter sample stream.
- Packs each trigger window into a frame: header, DATA_DELAY pre-trigger words plus all in-window words, then footer.
- Frames are buffered in an output FIFO and presented on an AXI4-Stream master to the DMA/readout path.

Parameters:
- CHANNEL_ID, 0, 8-bit channel tag written into header and footer.
- DATA_DELAY, 4, number of pre-trigger ADC words included ahead of the flag rise (1..64).
- FIFO_DEPTH, 512, output FIFO depth in TDATA words (power of two, >=8).
- TIME_STAMP_WIDTH, 16, width of TIME_STAMP (<=16).
- S_AXIS_TDATA_WIDTH, 128, sample-stream and output word width.

Ports:
- AXIS_ACLK  in  1  sole clock.
- AXIS_ARESET  in  1  asynchronous, active-high reset.
- EXEC_STATE  in  2  run state; frames open only while 2'b11 (TRG).
- TRIG_FLAG  in  1  trigger-window flag from the trigger stage.
- TIME_STAMP  in  TIME_STAMP_WIDTH  trigger time; valid from the cycle after TRIG_FLAG rises.
- S_AXIS_TDATA  in  S_AXIS_TDATA_WIDTH  raw ADC words, one per cycle, no handshake.
- M_AXIS_TDATA  out  S_AXIS_TDATA_WIDTH  frame word.
- M_AXIS_TVALID  out  1  FIFO not empty.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TLAST  out  1  high on footer word.
- DROP_COUNT  out  16  frames discarded, saturating.

Behaviour:
- Reset (async assert, sync release): FIFO emptied; M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0; DROP_COUNT=0; FSM=IDLE; flag pipeline f1/f2/f3=0.
- Reset mid-frame: frame lost, no footer emitted, DROP_COUNT not incremented.
- Flag pipeline: f1/f2/f3 are TRIG_FLAG delayed by 1/2/3 cycles.
- Data path: S_AXIS_TDATA delayed by DATA_DELAY+2 cycles through a shift register.
- Event strobes:
  - hdr_ev = f1 & !f2.
  - dat_ev = f2.
  - ftr_ev = !f2 & f3.
- Header word: [127:120]=8'hAA, [119:112]=CHANNEL_ID, [111:96]=TIME_STAMP zero-extended, remaining bits 0.
- Data word: the delayed S_AXIS_TDATA, unmodified.
- Footer word: [127:120]=8'h55, [119:112]=CHANNEL_ID, [111:96]=data words written (saturating at 16'hFFFF), [95]=overflow flag, remaining bits 0, TLAST=1.
- FSM IDLE:
  - on hdr_ev with EXEC_STATE==2'b11, no ftr_ev, and FIFO free >=3: write header, go BODY.
  - on hdr_ev otherwise: go SKIP and increment DROP_COUNT.
  - hdr_ev with EXEC_STATE!=2'b11 goes SKIP without incrementing.
- FSM BODY:
  - on dat_ev, if free >=2, write word and count++; else drop the word and set overflow.
  - One slot is always reserved for the footer.
  - on ftr_ev: write footer, clear count/overflow, go IDLE.
  - EXEC_STATE leaving 2'b11 mid-frame does not abort; the frame closes normally.
- FSM SKIP: dat_ev ignored; on ftr_ev go IDLE, no footer written.
- Collision hdr_ev & ftr_ev (flag low for exactly one cycle):
  - The footer of the closing frame is written.
  - The new header is refused: FSM goes SKIP, DROP_COUNT++.
- FIFO:
  - Single write per cycle (the strobes are mutually exclusive after the collision rule).
  - First-word-fall-through; pop on TVALID & TREADY.
  - Simultaneous push and pop when full or empty is legal and occupancy is unchanged.
  - Free-slot check uses occupancy at cycle start; a same-cycle pop does not count as free.
- AXIS: TDATA/TLAST held stable while TVALID & !TREADY.
- Latency: header enters the FIFO 1 cycle after TRIG_FLAG rises and appears on M_AXIS 1 cycle after that, if the FIFO was empty.
- Frame length equals flag-high cycles + 2 words (header and footer). The pre-trigger words come from the data path delay and are not extra words.

Test Plan:
- Ramp data (word k = k), DATA_DELAY=4, TREADY=1, TRIG_FLAG high for 10 cycles starting at the cycle where the input word is 100, TIME_STAMP=16'h1234 -> frame = header (AA,00,1234), data 96..105, footer (55,00,count=10,ovf=0) with TLAST.
- Same stimulus with TREADY=0 throughout and FIFO_DEPTH=8:
  - Header, then 5 data words (96..100) are written.
  - The remaining words are dropped with the footer slot reserved.
  - Footer shows count=5, ovf=1.
  - After TREADY=1, exactly 7 words drain, the last with TLAST.
- TRIG_FLAG pattern 1×6, 0×1, 1×6 -> first frame closes with count=6; second frame absent; DROP_COUNT=1; TLAST seen once.
- EXEC_STATE=2'b00 during a flag pulse -> no output words, DROP_COUNT stays 0.
- Same trigger in TRG, EXEC_STATE drops to 2'b00 mid-frame -> complete frame still emitted.
- AXIS_ARESET pulsed for 2 cycles mid-BODY (asynchronously, between clock edges) -> TVALID falls immediately, FIFO empty, DROP_COUNT=0. The next trigger yields a clean, correctly counted frame.
- TREADY toggled 1/0 every cycle over 3 back-to-back frames -> all words delivered in order, TDATA stable while stalled, 3 TLASTs.
